// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : alu_seq_pkg
//  Brief    : Opcode constants and FSM state encoding for alu_cmd_sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package alu_seq_pkg;

  // main_ALU opcodes
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  // Sequencer FSM states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_RESP    = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_cmd_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : alu_cmd_fifo
//  Brief    : DEPTH-entry synchronous FIFO holding packed {op, a, b} commands.
//             Head entry is presented combinationally on o_rdata.
//  Revision : 1.0  initial release
// ============================================================================
module alu_cmd_fifo #(
  parameter int DATA_W = 18,
  parameter int DEPTH  = 4
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic [DATA_W-1:0]            i_wdata,
  output logic [DATA_W-1:0]            o_rdata,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = $clog2(DEPTH+1);
  localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(DEPTH);

  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic               w_do_push;
  logic               w_do_pop;

  // Full/empty derive from the registered count only, so there is no
  // same-cycle bypass when the FIFO is full.
  assign o_full    = (r_count == c_full_cnt);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop  && !o_empty;

  // Storage write; contents need no reset since count gates visibility
  always_ff @(posedge clock) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_do_pop && !w_do_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_cmd_sequencer
//  Brief    : Issue stage in front of main_ALU. Queues commands, drives one
//             command at a time with operands held for the op latency, then
//             returns the captured result over a valid/ready port in order.
//  Revision : 1.0  initial release
// ============================================================================
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int ALU_WAIT = 2,
  parameter int MUL_WAIT = 12
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [1:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_y,
  input  logic [WIDTH-1:0] alu_z,
  input  logic             alu_o,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [1:0]       rsp_op,
  output logic [WIDTH-1:0] rsp_y,
  output logic [WIDTH-1:0] rsp_z,
  output logic             rsp_ovf,
  output logic             busy
);

  localparam int c_data_w = 2 + 2*WIDTH;
  localparam int c_cnt_w  = $clog2(MUL_WAIT+1);
  localparam logic [c_cnt_w-1:0] c_alu_load = c_cnt_w'(ALU_WAIT-2);
  localparam logic [c_cnt_w-1:0] c_mul_load = c_cnt_w'(MUL_WAIT-2);

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [c_cnt_w-1:0]         r_wait_cnt;
  logic [1:0]                 r_alu_op;
  logic [WIDTH-1:0]           r_alu_a;
  logic [WIDTH-1:0]           r_alu_b;
  logic                       r_rsp_valid;
  logic [1:0]                 r_rsp_op;
  logic [WIDTH-1:0]           r_rsp_y;
  logic [WIDTH-1:0]           r_rsp_z;
  logic                       r_rsp_ovf;

  logic                       w_pop;
  logic                       w_cnt_load;
  logic                       w_capture;
  logic                       w_rsp_clr;
  logic                       w_full;
  logic                       w_empty;
  logic [$clog2(DEPTH+1)-1:0] w_count;
  logic [c_data_w-1:0]        w_head;
  logic [c_cnt_w-1:0]         w_load_val;

  alu_cmd_fifo #(
    .DATA_W (c_data_w),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .i_push  (cmd_valid),
    .i_pop   (w_pop),
    .i_wdata ({cmd_op, cmd_a, cmd_b}),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign cmd_ready  = !w_full;
  assign busy       = (r_state != ST_IDLE) || (w_count != '0);
  assign alu_opcode = r_alu_op;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_op     = r_rsp_op;
  assign rsp_y      = r_rsp_y;
  assign rsp_z      = r_rsp_z;
  assign rsp_ovf    = r_rsp_ovf;

  // Wait-count preload chosen by the operation currently on the ALU
  always_comb begin
    w_load_val = c_alu_load;
    case (r_alu_op)
      OP_ADD, OP_AND, OP_XOR: w_load_val = c_alu_load;
      OP_MUL:                 w_load_val = c_mul_load;
      default:                w_load_val = c_alu_load;
    endcase
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and datapath strobes
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_cnt_load  = 1'b0;
    w_capture   = 1'b0;
    w_rsp_clr   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_cnt_load  = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (r_wait_cnt == '0) begin
          w_state_nxt = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        w_capture   = 1'b1;
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_rsp_clr = 1'b1;
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = ST_ISSUE;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Operand, wait counter and response registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wait_cnt  <= '0;
      r_alu_op    <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_op    <= '0;
      r_rsp_y     <= '0;
      r_rsp_z     <= '0;
      r_rsp_ovf   <= 1'b0;
    end else begin
      // Operands only change on a pop, so they stay put through CAPTURE
      if (w_pop) begin
        r_alu_op <= w_head[c_data_w-1 -: 2];
        r_alu_a  <= w_head[2*WIDTH-1 -: WIDTH];
        r_alu_b  <= w_head[WIDTH-1:0];
      end
      if (w_cnt_load) begin
        r_wait_cnt <= w_load_val;
      end else if ((r_state == ST_WAIT) && (r_wait_cnt != '0)) begin
        r_wait_cnt <= r_wait_cnt - 1'b1;
      end
      // Z and O are only meaningful for MUL and ADD respectively
      if (w_capture) begin
        r_rsp_valid <= 1'b1;
        r_rsp_op    <= r_alu_op;
        r_rsp_y     <= alu_y;
        r_rsp_z     <= (r_alu_op == OP_MUL) ? alu_z : '0;
        r_rsp_ovf   <= (r_alu_op == OP_ADD) ? alu_o : 1'b0;
      end else if (w_rsp_clr) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_cmd_sequencer
//  Brief    : Directed self-checking bench for alu_cmd_sequencer with a
//             behavioural main_ALU that only settles after operands are stable.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_cmd_sequencer;
  import alu_seq_pkg::*;

  localparam int WIDTH    = 8;
  localparam int DEPTH    = 4;
  localparam int ALU_WAIT = 2;
  localparam int MUL_WAIT = 12;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic [1:0]  alu_opcode;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [7:0]  alu_y;
  logic [7:0]  alu_z;
  logic        alu_o;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_op;
  logic [7:0]  rsp_y;
  logic [7:0]  rsp_z;
  logic        rsp_ovf;
  logic        busy;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  alu_cmd_sequencer #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .ALU_WAIT (ALU_WAIT),
    .MUL_WAIT (MUL_WAIT)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_y      (alu_y),
    .alu_z      (alu_z),
    .alu_o      (alu_o),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_op     (rsp_op),
    .rsp_y      (rsp_y),
    .rsp_z      (rsp_z),
    .rsp_ovf    (rsp_ovf),
    .busy       (busy)
  );

  // Behavioural main_ALU: outputs junk until operands have been stable long
  // enough; Z and O carry junk for ops where they are not meaningful.
  logic [1:0]         m_op;
  logic [7:0]         m_a;
  logic [7:0]         m_b;
  int                 m_stab = 0;
  int                 m_lat;
  logic               m_ok;
  logic [7:0]         m_sum;
  logic signed [15:0] m_prod;

  always @(posedge clock) begin
    m_op <= alu_opcode;
    m_a  <= alu_a;
    m_b  <= alu_b;
    if (alu_opcode != m_op || alu_a != m_a || alu_b != m_b) m_stab <= 0;
    else if (m_stab < 1000) m_stab <= m_stab + 1;
  end

  always_comb begin
    m_lat  = (alu_opcode == OP_MUL) ? 9 : 1;
    m_ok   = (alu_opcode == m_op) && (alu_a == m_a) && (alu_b == m_b) && (m_stab >= m_lat);
    m_sum  = alu_a + alu_b;
    m_prod = $signed(alu_a) * $signed(alu_b);
    alu_y  = 8'hEE;
    alu_z  = 8'hEE;
    alu_o  = 1'b1;
    if (m_ok) begin
      case (alu_opcode)
        OP_ADD: begin
          if ((alu_a[7] == alu_b[7]) && (m_sum[7] != alu_a[7])) begin
            alu_y = 8'h00;
            alu_o = 1'b1;
          end else begin
            alu_y = m_sum;
            alu_o = 1'b0;
          end
          alu_z = 8'hA5;
        end
        OP_AND: begin alu_y = alu_a & alu_b; alu_z = 8'hA5; alu_o = 1'b1; end
        OP_XOR: begin alu_y = alu_a ^ alu_b; alu_z = 8'hA5; alu_o = 1'b1; end
        default: begin alu_y = m_prod[7:0]; alu_z = m_prod[15:8]; alu_o = 1'b1; end
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a command from a negedge and hold it until it is accepted
  task automatic push(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    while (!cmd_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!cmd_ready) chk("push_timeout", 32'(cmd_ready), 32'd1);
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!rsp_valid) chk("rsp_timeout", 32'(rsp_valid), 32'd1);
  endtask

  task automatic check_rsp(input string tag, input logic [1:0] op, input logic [7:0] y,
                           input logic [7:0] z, input logic ovf);
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_op"},    32'(rsp_op),    32'(op));
    chk({tag, "_y"},     32'(rsp_y),     32'(y));
    chk({tag, "_z"},     32'(rsp_z),     32'(z));
    chk({tag, "_ovf"},   32'(rsp_ovf),   32'(ovf));
  endtask

  // Wait for a response (rsp_ready already high), check it, let it be taken
  task automatic drain_one(input string tag, input logic [1:0] op, input logic [7:0] y,
                           input logic [7:0] z, input logic ovf);
    int n;
    wait_rsp(n);
    check_rsp(tag, op, y, z, ovf);
    @(negedge clock);
  endtask

  // Single command from an idle sequencer with latency measurement
  task automatic run_one(input string tag, input logic [1:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] y, input logic [7:0] z,
                         input logic ovf, input int lat);
    int n;
    push(op, a, b);
    wait_rsp(n);
    chk({tag, "_lat"}, 32'(n), 32'(lat));
    check_rsp(tag, op, y, z, ovf);
    chk({tag, "_alu_op"}, 32'(alu_opcode), 32'(op));
    chk({tag, "_alu_a"},  32'(alu_a),      32'(a));
    chk({tag, "_alu_b"},  32'(alu_b),      32'(b));
    @(negedge clock);
    chk({tag, "_done"}, {30'd0, rsp_valid, busy}, 32'd0);
  endtask

  initial begin
    int n;
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_a     = 8'h00;
    cmd_b     = 8'h00;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clock);

    // Reset state
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_alu",       {14'd0, alu_opcode, alu_a, alu_b}, 32'd0);
    chk("rst_rsp",       {13'd0, rsp_op, rsp_y, rsp_z, rsp_ovf}, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // Single commands: ADD, ADD overflow both signs, MUL, AND, XOR
    run_one("add",     OP_ADD, 8'h05, 8'h03, 8'h08, 8'h00, 1'b0, ALU_WAIT + 2);
    run_one("add_ovp", OP_ADD, 8'h70, 8'h20, 8'h00, 8'h00, 1'b1, ALU_WAIT + 2);
    run_one("add_ovn", OP_ADD, 8'h90, 8'h90, 8'h00, 8'h00, 1'b1, ALU_WAIT + 2);
    run_one("mul_pos", OP_MUL, 8'h03, 8'h04, 8'h0C, 8'h00, 1'b0, MUL_WAIT + 2);
    run_one("mul_neg", OP_MUL, 8'hFD, 8'h04, 8'hF4, 8'hFF, 1'b0, MUL_WAIT + 2);
    run_one("and",     OP_AND, 8'hF0, 8'h3C, 8'h30, 8'h00, 1'b0, ALU_WAIT + 2);
    run_one("xor",     OP_XOR, 8'hF0, 8'h3C, 8'hCC, 8'h00, 1'b0, ALU_WAIT + 2);

    // Back-pressure: DEPTH+1 commands accepted, the sixth is refused
    rsp_ready = 1'b0;
    push(OP_ADD, 8'h01, 8'h01);
    push(OP_AND, 8'hFF, 8'h0F);
    push(OP_XOR, 8'hAA, 8'h55);
    push(OP_MUL, 8'h02, 8'h03);
    push(OP_ADD, 8'h10, 8'h20);
    cmd_valid = 1'b1;
    cmd_op    = OP_XOR;
    cmd_a     = 8'h11;
    cmd_b     = 8'h22;
    chk("full_ready_0", 32'(cmd_ready), 32'd0);
    repeat (3) @(negedge clock);
    chk("full_ready_3", 32'(cmd_ready), 32'd0);
    chk("full_busy",    32'(busy),      32'd1);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    drain_one("bp0", OP_ADD, 8'h02, 8'h00, 1'b0);
    drain_one("bp1", OP_AND, 8'h0F, 8'h00, 1'b0);
    drain_one("bp2", OP_XOR, 8'hFF, 8'h00, 1'b0);
    drain_one("bp3", OP_MUL, 8'h06, 8'h00, 1'b0);
    drain_one("bp4", OP_ADD, 8'h30, 8'h00, 1'b0);
    chk("bp_busy", 32'(busy), 32'd0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (rsp_valid) n++;
    end
    chk("bp_no_sixth", 32'(n), 32'd0);

    // Reset during WAIT of a MUL with two commands queued
    push(OP_MUL, 8'h05, 8'h06);
    push(OP_ADD, 8'h01, 8'h02);
    push(OP_ADD, 8'h03, 8'h04);
    repeat (3) @(negedge clock);
    chk("mid_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rst_busy",  32'(busy),      32'd0);
    chk("mid_rst_alu",   {14'd0, alu_opcode, alu_a, alu_b}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (rsp_valid || busy) n++;
    end
    chk("mid_no_rsp", 32'(n), 32'd0);

    // Response held stable under back-pressure
    rsp_ready = 1'b0;
    push(OP_ADD, 8'h05, 8'h03);
    wait_rsp(n);
    for (int i = 0; i < 20; i++) begin
      chk("hold", {12'd0, rsp_valid, rsp_op, rsp_ovf, rsp_z, rsp_y},
          {12'd0, 1'b1, 2'b00, 1'b0, 8'h00, 8'h08});
      @(negedge clock);
    end

    // Simultaneous push and pop with three queued keeps the count at three
    push(OP_AND, 8'hF0, 8'h3C);
    push(OP_XOR, 8'hF0, 8'h3C);
    push(OP_MUL, 8'h03, 8'h04);
    chk("three_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = OP_ADD;
    cmd_a     = 8'h70;
    cmd_b     = 8'h20;
    rsp_ready = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    chk("pushpop_ready", 32'(cmd_ready), 32'd1);
    push(OP_MUL, 8'hFD, 8'h04);
    chk("pushpop_full", 32'(cmd_ready), 32'd0);
    rsp_ready = 1'b1;
    drain_one("pp0", OP_AND, 8'h30, 8'h00, 1'b0);
    drain_one("pp1", OP_XOR, 8'hCC, 8'h00, 1'b0);
    drain_one("pp2", OP_MUL, 8'h0C, 8'h00, 1'b0);
    drain_one("pp3", OP_ADD, 8'h00, 8'h00, 1'b1);
    drain_one("pp4", OP_MUL, 8'hF4, 8'hFF, 1'b0);
    chk("pp_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
